gat_feat_readback: RTL and testbench

Host-side reader for the GAT new-feature output BRAM. After the accelerator raises `gat_ready`, this block walks the feature BRAM's port B from word 0 to the last word and streams each word out on a valid/ready stream toward the DMA/host. It handles the BRAM's one-cycle read latency under arbitrary backpressure with no lost or duplicated words. It sits between the accelerator wrapper's `feat_bram_addrb`/`feat_bram_dout` pins and the host stream fabric.

---
 rtl/gat_feat_readback.sv | 132 +++++++++++++
 tb/tb_gat_feat_readback.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/gat_feat_readback.sv
// Streams the GAT new-feature BRAM out over valid/ready after each gat_ready rise.
// Optional FEAT_RB_ROW_LAST_EN: m_tlast per subgraph row instead of once per dump.
module gat_feat_readback #(
  parameter int TOP_WIDTH          = 32,
  parameter int NEW_FEATURE_WIDTH  = 32,
  parameter int NUM_SUBGRAPHS      = 2708,
  parameter int NUM_FEATURE_OUT    = 16,
  parameter int NEW_FEATURE_DEPTH  = NUM_SUBGRAPHS * NUM_FEATURE_OUT,
  parameter int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          gat_ready,
  output logic [NEW_FEATURE_ADDR_W+1:0] feat_bram_addrb,
  input  logic [NEW_FEATURE_WIDTH-1:0]  feat_bram_dout,
  output logic [TOP_WIDTH-1:0]          m_tdata,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic                          m_tlast,
  output logic                          rd_busy,
  output logic                          rd_done
);
  localparam int CNT_W = NEW_FEATURE_ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(NEW_FEATURE_DEPTH);
  localparam logic [NEW_FEATURE_ADDR_W-1:0] LAST_IDX = NEW_FEATURE_ADDR_W'(NEW_FEATURE_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  typedef struct packed {
    logic                         last;
    logic [NEW_FEATURE_WIDTH-1:0] data;
  } entry_t;

  state_t                        state;
  logic                          gat_ready_q;
  logic [CNT_W-1:0]              issue_cnt, accept_cnt;
  logic [NEW_FEATURE_ADDR_W-1:0] widx;
  logic                          inflight, inflight_last;
  entry_t                        fifo_mem [2];
  entry_t                        wr_entry;
  logic                          rd_ptr, wr_ptr;
  logic [1:0]                    fifo_count;
  logic                          start, issue, pop, issue_last;
  logic [2:0]                    occ;

  assign start    = (state == IDLE) && gat_ready && !gat_ready_q;
  assign m_tvalid = (fifo_count != 2'd0);
  assign pop      = m_tvalid && m_tready;
  // Credit counts the slot freed by this cycle's pop, so a full-rate stream never bubbles.
  assign occ      = {1'b0, fifo_count} + {2'b0, inflight} - {2'b0, pop};
  assign issue    = (state == RUN) && (issue_cnt != DEPTH_C) && (occ < 3'd2);

  // widx is the address being read this cycle; the BRAM samples it at the next edge.
  assign feat_bram_addrb = {widx, 2'b00};

`ifdef FEAT_RB_ROW_LAST_EN
  localparam int COL_W = (NUM_FEATURE_OUT > 1) ? $clog2(NUM_FEATURE_OUT) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_FEATURE_OUT - 1);
  logic [COL_W-1:0] col;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)     col <= '0;
    else if (start) col <= '0;
    else if (issue) col <= (col == LAST_COL) ? '0 : col + COL_W'(1);

  assign issue_last = (col == LAST_COL);
`else
  assign issue_last = (widx == LAST_IDX);
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state         <= IDLE;
      gat_ready_q   <= 1'b0;
      issue_cnt     <= '0;
      accept_cnt    <= '0;
      widx          <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      rd_busy       <= 1'b0;
      rd_done       <= 1'b0;
    end else begin
      gat_ready_q   <= gat_ready;
      inflight      <= issue;
      inflight_last <= issue && issue_last;
      if (issue) begin
        issue_cnt <= issue_cnt + 1'b1;
        if (widx != LAST_IDX) widx <= widx + 1'b1;
      end
      if (pop) accept_cnt <= accept_cnt + 1'b1;
      case (state)
        IDLE: if (start) begin
          state      <= RUN;
          issue_cnt  <= '0;
          accept_cnt <= '0;
          widx       <= '0;
          rd_busy    <= 1'b1;
        end
        RUN:   if (issue_cnt == DEPTH_C) state <= DRAIN;
        DRAIN: if (accept_cnt == DEPTH_C) begin
          state   <= DONE;
          rd_busy <= 1'b0;
          rd_done <= 1'b1;
        end
        DONE: if (!gat_ready) begin
          state   <= IDLE;
          rd_done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end

  assign wr_entry = '{last: inflight_last, data: feat_bram_dout};

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      fifo_count  <= 2'd0;
    end else begin
      if (inflight) begin
        fifo_mem[wr_ptr] <= wr_entry;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      fifo_count <= fifo_count + {1'b0, inflight} - {1'b0, pop};
    end

  assign m_tdata = TOP_WIDTH'(fifo_mem[rd_ptr].data);
  assign m_tlast = m_tvalid && fifo_mem[rd_ptr].last;
endmodule

// File: tb/tb_gat_feat_readback.sv
// Bench for gat_feat_readback: 3x4 feature BRAM, scenario table plus reset-mid-dump sequence.
module tb_gat_feat_readback;
  localparam int NSG   = 3;
  localparam int NFO   = 4;
  localparam int DEPTH = NSG * NFO;
  localparam int AW    = $clog2(DEPTH);
`ifdef FEAT_RB_ROW_LAST_EN
  localparam bit ROW_LAST = 1'b1;
`else
  localparam bit ROW_LAST = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n, gat_ready, m_tready, m_tvalid, m_tlast, rd_busy, rd_done;
  logic [AW+1:0] feat_bram_addrb;
  logic [31:0]   feat_bram_dout, m_tdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Synchronous-read BRAM: word i reads as 0xA000_0000 + i
  always @(posedge clk) feat_bram_dout <= 32'hA000_0000 + 32'(feat_bram_addrb >> 2);

  gat_feat_readback #(
    .TOP_WIDTH(32), .NEW_FEATURE_WIDTH(32), .NUM_SUBGRAPHS(NSG), .NUM_FEATURE_OUT(NFO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .gat_ready(gat_ready),
    .feat_bram_addrb(feat_bram_addrb), .feat_bram_dout(feat_bram_dout),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .rd_busy(rd_busy), .rd_done(rd_done)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // mode 0: ready always, 1: ready pattern 1,0,0,1 by cycle, 2: random ready
  task automatic run_dump(input int mode, input int exp_done_n, input bit hold);
    logic [31:0] exp_q[$];
    bit          exp_l[$];
    logic [31:0] stall_d;
    bit          stall_l, stalled, r, finished;
    int          nacc, last_n, first_n;
    for (int i = 0; i < DEPTH; i++) begin
      exp_q.push_back(32'hA000_0000 + 32'(i));
      exp_l.push_back(ROW_LAST ? ((i % NFO) == NFO - 1) : (i == DEPTH - 1));
    end
    nacc = 0; last_n = -1; first_n = -1; stalled = 0; finished = 0;
    stall_d = '0; stall_l = 0;
    gat_ready = 1'b1;
    @(negedge clk);
    for (int n = 0; n < 200 && !finished; n++) begin
      if (n == 0) check("addr_start", 32'(feat_bram_addrb), 32'd0);
      check("addr_range", 32'(feat_bram_addrb <= (AW+2)'(4*(DEPTH-1)) && feat_bram_addrb[1:0] == 2'b00), 32'd1);
      if (stalled) begin
        check("stall_valid", 32'(m_tvalid), 32'd1);
        check("stall_data", m_tdata, stall_d);
        check("stall_last", 32'(m_tlast), 32'(stall_l));
      end
      if (nacc == DEPTH) begin
        check("no_extra_word", 32'(m_tvalid), 32'd0);
        if (n == last_n + 1) check("busy_tail", {30'd0, rd_busy, rd_done}, 32'b10);
        else begin
          check("done_flags", {30'd0, rd_busy, rd_done}, 32'b01);
          if (exp_done_n >= 0) check("done_cycle", 32'(n), 32'(exp_done_n));
          finished = 1;
        end
        stalled = 0;
      end else begin
        check("busy_run", {30'd0, rd_busy, rd_done}, 32'b10);
        if (first_n < 0 && m_tvalid) begin
          first_n = n;
          check("first_valid_cycle", 32'(n), 32'd2);
        end
        if (first_n >= 0) check("no_bubble", 32'(m_tvalid), 32'd1);
        case (mode)
          0:       r = 1'b1;
          1:       r = ((n % 4) == 0) || ((n % 4) == 3);
          default: r = 1'($urandom_range(0, 1));
        endcase
        m_tready = r;
        if (m_tvalid && r) begin
          check("word_data", m_tdata, exp_q[nacc]);
          check("word_last", 32'(m_tlast), 32'(exp_l[nacc]));
          nacc++;
          if (nacc == DEPTH) last_n = n;
        end
        stalled = m_tvalid && !r;
        stall_d = m_tdata;
        stall_l = m_tlast;
      end
      if (!finished) @(negedge clk);
    end
    if (!finished) begin
      errors++;
      $display("FAIL dump_timeout: accepted %0d words, required %0d", nacc, DEPTH);
    end
    if (hold) begin
      repeat (4) begin
        @(negedge clk);
        check("hold_no_redump", {29'd0, m_tvalid, rd_busy, rd_done}, 32'b001);
      end
    end
    gat_ready = 1'b0;
    @(negedge clk);
    check("idle_after_drop", {30'd0, rd_busy, rd_done}, 32'b00);
    @(negedge clk);
  endtask

  typedef struct {
    int mode;
    int exp_done_n;
    bit hold;
  } vec_t;

  vec_t vecs[4];
  int   nacc;
  bit   got6;

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    vecs[0] = '{mode: 0, exp_done_n: 15, hold: 1'b0};
    vecs[1] = '{mode: 1, exp_done_n: 26, hold: 1'b1};
    vecs[2] = '{mode: 2, exp_done_n: -1, hold: 1'b0};
    vecs[3] = '{mode: 0, exp_done_n: 15, hold: 1'b1};

    rst_n = 1'b0; gat_ready = 1'b0; m_tready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_addr", 32'(feat_bram_addrb), 32'd0);
    check("rst_tdata", m_tdata, 32'd0);
    check("rst_flags", {28'd0, m_tvalid, m_tlast, rd_busy, rd_done}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 4; v++) run_dump(vecs[v].mode, vecs[v].exp_done_n, vecs[v].hold);

    // Reset after word 5 is accepted, then a fresh dump must restart at word 0
    gat_ready = 1'b1; m_tready = 1'b1; nacc = 0; got6 = 0;
    for (int n = 0; n < 50 && !got6; n++) begin
      @(negedge clk);
      if (m_tvalid) begin
        check("pre_rst_data", m_tdata, 32'hA000_0000 + 32'(nacc));
        nacc++;
        if (nacc == 6) got6 = 1;
      end
    end
    if (!got6) begin
      errors++;
      $display("FAIL pre_rst_timeout: accepted %0d words, required 6", nacc);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0; gat_ready = 1'b0;
    @(negedge clk);
    check("midrst_addr", 32'(feat_bram_addrb), 32'd0);
    check("midrst_tdata", m_tdata, 32'd0);
    check("midrst_flags", {28'd0, m_tvalid, m_tlast, rd_busy, rd_done}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_idle", {30'd0, m_tvalid, rd_busy}, 32'd0);
    run_dump(0, 15, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
